// File: rtl/i2s_pkg.sv
// i2s_pkg: constants and sync-state type shared by the I2S receiver and transmitter.
package i2s_pkg;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_CNT_W = 6;
  localparam logic I2S_CH_LEFT = 1'b0;
  localparam logic I2S_CH_RIGHT = 1'b1;
  typedef enum logic [1:0] {SYNC_IDLE, SYNC_HUNT, SYNC_RUN} sync_e;
endpackage

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: 2-flop synchronisers for sclk/lrclk/din plus a registered sclk rise strobe.
// lrclk/din are re-registered alongside the strobe so all three stay cycle-aligned.
module i2s_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic lrclk_i,
  input  logic din_i,
  output logic rise_o,
  output logic lrclk_o,
  output logic din_o
);
  logic [1:0] sclk_q, lr_q, din_q;
  logic sclk_prev_q, rise_q, lr_out_q, din_out_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q <= '0;
      lr_q <= '0;
      din_q <= '0;
      sclk_prev_q <= 1'b0;
      rise_q <= 1'b0;
      lr_out_q <= 1'b0;
      din_out_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[0], sclk_i};
      lr_q <= {lr_q[0], lrclk_i};
      din_q <= {din_q[0], din_i};
      sclk_prev_q <= sclk_q[1];
      rise_q <= sclk_q[1] & ~sclk_prev_q;
      lr_out_q <= lr_q[1];
      din_out_q <= din_q[1];
    end
  end
  assign rise_o = rise_q;
  assign lrclk_o = lr_out_q;
  assign din_o = din_out_q;
endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: slave-mode I2S capture of 32-bit slots into parallel L/R samples.
// Optional I2S_RECEIVER_FRAME_CHECK_EN: slots not exactly 32 bits raise frame_err and are dropped.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter bit RIGHT_JUSTIFY = 1'b1
) (
  input  logic clk48m,
  input  logic rst,
  input  logic sclk,
  input  logic lrclk,
  input  logic din,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic sample_valid,
  output logic frame_err
);
  logic rise, lr, d;
  sync_e state_q, state_d;
  logic lr_prev_q, lr_prev_d, armed_q, armed_d, valid_q, valid_d, err_q, err_d;
  logic [I2S_SLOT_BITS-2:0] sr_q, sr_d;
  logic [I2S_SLOT_BITS-1:0] slot;
  logic [SAMPLE_WIDTH-1:0] sample, stage_q, stage_d, left_q, left_d, right_q, right_d;
  logic change, commit, commit_l, commit_r, bad;

  i2s_rx_sync u_sync (
    .clk_i(clk48m),
    .rst_i(rst),
    .sclk_i(sclk),
    .lrclk_i(lrclk),
    .din_i(din),
    .rise_o(rise),
    .lrclk_o(lr),
    .din_o(d)
  );

  assign change = rise && (lr != lr_prev_q);
  assign commit = change && (state_q == SYNC_RUN);
  assign slot = {sr_q, d};
  assign sample = SAMPLE_WIDTH'(RIGHT_JUSTIFY ? slot : (slot >> (I2S_SLOT_BITS - SAMPLE_WIDTH)));

`ifdef I2S_RECEIVER_FRAME_CHECK_EN
  logic [I2S_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign cnt_d = rise ? (change ? '0 : cnt_inc) : cnt_q;
  assign bad = cnt_inc != I2S_CNT_W'(I2S_SLOT_BITS);
  always_ff @(posedge clk48m) cnt_q <= rst ? '0 : cnt_d;
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk48m) begin
    if (rst) begin
      state_q <= SYNC_IDLE;
      lr_prev_q <= 1'b0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      sr_q <= '0;
      stage_q <= '0;
      left_q <= '0;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      lr_prev_q <= lr_prev_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      err_q <= err_d;
      sr_q <= sr_d;
      stage_q <= stage_d;
      left_q <= left_d;
      right_q <= right_d;
    end
  end

  // The first rise only records lrclk; the next lrclk change marks the first real slot boundary.
  always_comb begin
    state_d = !rise ? state_q : (state_q == SYNC_IDLE) ? SYNC_HUNT : change ? SYNC_RUN : state_q;
  end

  always_comb begin
    commit_l = commit && (lr_prev_q == I2S_CH_LEFT);
    commit_r = commit && (lr_prev_q != I2S_CH_LEFT);
    lr_prev_d = rise ? lr : lr_prev_q;
    sr_d = rise ? (change ? '0 : slot[I2S_SLOT_BITS-2:0]) : sr_q;
    stage_d = (commit_l && !bad) ? sample : stage_q;
    armed_d = commit_l ? !bad : commit_r ? 1'b0 : armed_q;
    valid_d = commit_r && !bad && armed_q;
    err_d = commit && bad;
    left_d = valid_d ? stage_q : left_q;
    right_d = valid_d ? sample : right_q;
  end

  assign left_sample = left_q;
  assign right_sample = right_q;
  assign sample_valid = valid_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed I2S frames into LSB- and MSB-aligned receiver instances.
module tb_i2s_receiver;
  logic clk48m = 1'b0, rst = 1'b1, sclk = 1'b0, lrclk = 1'b0, din = 1'b0;
  logic [15:0] left_sample, right_sample, left_msb, right_msb;
  logic sample_valid, frame_err, valid_msb, err_msb;
  int checks = 0, failures = 0, vcnt = 0, ecnt = 0, lat = 0;

  always #5 clk48m = ~clk48m;

  i2s_receiver #(.SAMPLE_WIDTH(16), .RIGHT_JUSTIFY(1'b1)) dut (
    .clk48m(clk48m), .rst(rst), .sclk(sclk), .lrclk(lrclk), .din(din),
    .left_sample(left_sample), .right_sample(right_sample),
    .sample_valid(sample_valid), .frame_err(frame_err)
  );

  i2s_receiver #(.SAMPLE_WIDTH(16), .RIGHT_JUSTIFY(1'b0)) dut_msb (
    .clk48m(clk48m), .rst(rst), .sclk(sclk), .lrclk(lrclk), .din(din),
    .left_sample(left_msb), .right_sample(right_msb),
    .sample_valid(valid_msb), .frame_err(err_msb)
  );

  always @(negedge clk48m) begin
    if (sample_valid) vcnt++;
    if (frame_err) ecnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bit cell: 16 clk48m low, 16 high; lat records cycles from the rise to any sample_valid.
  task automatic send_bit(input logic l, input logic b);
    sclk = 1'b0;
    lrclk = l;
    din = b;
    repeat (16) @(negedge clk48m);
    sclk = 1'b1;
    lat = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk48m);
      if (sample_valid && lat == 0) lat = i;
    end
  endtask

  task automatic send_slot(input logic ch, input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 1; i--) send_bit(ch, w[i]);
    send_bit(~ch, w[0]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  initial begin
    logic [31:0] w;
    int v0, e0;
    repeat (3) @(negedge clk48m);
    check("rst_left", left_sample, 0);
    check("rst_right", right_sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_err", frame_err, 0);
    rst = 1'b0;

    send_slot(1'b0, 32'h0000_00AB, 8);
    send_slot(1'b1, 32'h0000_BEEF, 32);
    check("partial_no_pulse", vcnt, 0);

    send_frame(32'h0000_1234, 32'h0000_BEEF);
    check("f1_count", vcnt, 1);
    check("f1_left", left_sample, 16'h1234);
    check("f1_right", right_sample, 16'hBEEF);
    check("latency_3to5", (lat >= 3 && lat <= 5), 1);
    send_frame(32'h0000_1234, 32'h0000_BEEF);
    check("f2_count", vcnt, 2);
    check("f2_left", left_sample, 16'h1234);
    check("f2_right", right_sample, 16'hBEEF);

    send_slot(1'b0, 32'h0000_1111, 32);
    w = 32'h0000_2222;
    for (int i = 31; i >= 16; i--) send_bit(1'b1, w[i]);
    rst = 1'b1;
    @(negedge clk48m);
    check("midrst_left", left_sample, 0);
    check("midrst_right", right_sample, 0);
    check("midrst_valid", sample_valid, 0);
    rst = 1'b0;
    for (int i = 15; i >= 1; i--) send_bit(1'b1, w[i]);
    send_bit(1'b0, w[0]);
    check("midrst_no_pulse", vcnt, 2);
    send_frame(32'h0000_1111, 32'h0000_2222);
    check("resync_count", vcnt, 3);
    check("resync_left", left_sample, 16'h1111);
    check("resync_right", right_sample, 16'h2222);

    send_frame(32'hA5A5_0000, 32'h5A5A_0000);
    check("msb_count", vcnt, 4);
    check("msb_left", left_msb, 16'hA5A5);
    check("msb_right", right_msb, 16'h5A5A);
    check("lsb_left_of_msb_data", left_sample, 16'h0000);
    check("lsb_right_of_msb_data", right_sample, 16'h0000);

    v0 = vcnt;
    e0 = ecnt;
    send_slot(1'b0, 32'h0000_1234, 31);
    send_slot(1'b1, 32'h0000_BEEF, 32);
`ifdef I2S_RECEIVER_FRAME_CHECK_EN
    check("short_err", ecnt, e0 + 1);
    check("short_no_pulse", vcnt, v0);
    v0 = v0 + 1;
`else
    check("short_err_tied", ecnt, 0);
    check("short_pulse", vcnt, v0 + 1);
    check("short_left", left_sample, 16'h1234);
    v0 = v0 + 2;
`endif
    send_frame(32'h0000_4321, 32'h0000_8765);
    check("after_short_count", vcnt, v0);
    check("after_short_left", left_sample, 16'h4321);
    check("after_short_right", right_sample, 16'h8765);

    for (int k = 0; k < 8; k++) begin
      v0 = vcnt;
      send_frame((k % 2 == 0) ? 32'h0000_FFFF : 32'h0, (k % 2 == 0) ? 32'h0 : 32'h0000_FFFF);
      check("alt_count", vcnt, v0 + 1);
      check("alt_left", left_sample, (k % 2 == 0) ? 16'hFFFF : 16'h0000);
      check("alt_right", right_sample, (k % 2 == 0) ? 16'h0000 : 16'hFFFF);
    end
`ifndef I2S_RECEIVER_FRAME_CHECK_EN
    check("err_never", ecnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
